axis_peak_arb: RTL

- Packet-level round-robin arbiter merging burst streams from several axis_peak_detn instances (one per antenna group) onto one AXI-stream toward the DMA/packetizer.
- Each burst is forwarded intact, preceded by an optional header word carrying source index and per-source sequence number.
- Enforces a maximum burst length, so a source that never asserts tlast cannot lock the output.

---
 rtl/axis_peak_arb.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/axis_peak_arb.sv
// ---------------------------------------------------------------------------------------------
// axis_peak_arb
//
// Packet-level round-robin arbiter that merges burst streams from several upstream
// peak detectors onto a single AXI-stream. A granted source keeps the output until its
// burst ends, so bursts are never interleaved. Each burst may be preceded by a header
// beat carrying the source index and a per-source sequence number. A burst longer than
// MAX_BEATS is cut with a forced tlast, so a source that never ends its burst cannot
// hold the output forever.
//
// Ports:
//   clk            core clock
//   rst            asynchronous active-high reset
//   s_axis_tvalid  per-source valid
//   s_axis_tready  per-source ready (only the granted source, only in the data phase)
//   s_axis_tdata   packed source data, source k at [k*DATA_WIDTH +: DATA_WIDTH]
//   s_axis_tlast   per-source end of burst
//   m_axis_tvalid  registered output valid
//   m_axis_tready  output ready
//   m_axis_tdata   registered output data
//   m_axis_tlast   registered output end of burst
//   grant          one-hot granted source, zero while idle
//   overrun        one-cycle pulse, aligned with the truncated beat on the output
// ---------------------------------------------------------------------------------------------

module axis_peak_arb #(
    parameter int unsigned NUM_SOURCES   = 2,
    parameter int unsigned DATA_WIDTH    = 256,
    parameter int unsigned SEQ_WIDTH     = 16,
    parameter int unsigned MAX_BEATS     = 32,
    parameter int unsigned INSERT_HEADER = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_SOURCES-1:0]            s_axis_tvalid,
    output logic [NUM_SOURCES-1:0]            s_axis_tready,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SOURCES-1:0]            s_axis_tlast,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic [DATA_WIDTH-1:0]             m_axis_tdata,
    output logic                              m_axis_tlast,
    output logic [NUM_SOURCES-1:0]            grant,
    output logic                              overrun
);

    localparam int unsigned IdxW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
    localparam int unsigned CntW = $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {
        StIdle,
        StHdr,
        StData
    } state_e;

    // ---------------------------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------------------------
    state_e                  state_q;
    logic [NUM_SOURCES-1:0]  grant_q;
    logic [IdxW-1:0]         last_q;      // last granted source; also the current owner
    logic [CntW-1:0]         cnt_q;       // data beats accepted in the current burst
    logic [SEQ_WIDTH-1:0]    seq_q [NUM_SOURCES];
    logic                    m_valid_q;
    logic [DATA_WIDTH-1:0]   m_data_q;
    logic                    m_last_q;
    logic                    overrun_q;

    // ---------------------------------------------------------------------------------------
    // Combinational helpers
    // ---------------------------------------------------------------------------------------
    logic                    out_ready;
    logic                    req_any;
    logic [IdxW-1:0]         req_idx;
    int                      arb_cand;
    logic                    sel_valid;
    logic                    sel_last;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    beat_acc;
    logic                    at_max;
    logic                    burst_end;
    logic [DATA_WIDTH-1:0]   hdr_word;

    // The output register can take a new word when empty or when its word leaves this cycle.
    assign out_ready = ~m_valid_q | m_axis_tready;

    // Round-robin search starting just after the last granted source.
    always_comb begin
        req_any  = 1'b0;
        req_idx  = '0;
        arb_cand = 0;
        for (int i = 1; i <= int'(NUM_SOURCES); i++) begin
            arb_cand = (int'(last_q) + i) % int'(NUM_SOURCES);
            if (!req_any && s_axis_tvalid[arb_cand]) begin
                req_any = 1'b1;
                req_idx = IdxW'(arb_cand);
            end
        end
    end

    // Granted-source mux, driven by the one-hot grant so no index arithmetic is needed.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int k = 0; k < int'(NUM_SOURCES); k++) begin
            if (grant_q[k]) begin
                sel_valid = s_axis_tvalid[k];
                sel_last  = s_axis_tlast[k];
                sel_data  = s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        hdr_word                  = '0;
        hdr_word[7:0]             = 8'(last_q);
        hdr_word[8 +: SEQ_WIDTH]  = seq_q[last_q];
    end

    assign beat_acc  = (state_q == StData) & sel_valid & out_ready;
    // This beat would be the MAX_BEATS-th of the burst.
    assign at_max    = (cnt_q == CntW'(MAX_BEATS - 1));
    assign burst_end = beat_acc & (sel_last | at_max);

    assign s_axis_tready = ((state_q == StData) && out_ready) ? grant_q : '0;

    // ---------------------------------------------------------------------------------------
    // FSM with registered outputs
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            last_q    <= IdxW'(NUM_SOURCES - 1);
            cnt_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            overrun_q <= 1'b0;
            for (int k = 0; k < int'(NUM_SOURCES); k++) begin
                seq_q[k] <= '0;
            end
        end else begin
            overrun_q <= 1'b0;
            // A drained word leaves; a load below overrides this in the same cycle.
            if (out_ready) begin
                m_valid_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (req_any) begin
                        grant_q <= NUM_SOURCES'(1) << req_idx;
                        last_q  <= req_idx;
                        cnt_q   <= '0;
                        state_q <= (INSERT_HEADER != 0) ? StHdr : StData;
                    end
                end

                StHdr: begin
                    if (out_ready) begin
                        m_valid_q <= 1'b1;
                        m_data_q  <= hdr_word;
                        m_last_q  <= 1'b0;
                        state_q   <= StData;
                    end
                end

                StData: begin
                    if (beat_acc) begin
                        m_valid_q <= 1'b1;
                        m_data_q  <= sel_data;
                        m_last_q  <= sel_last | at_max;
                        cnt_q     <= cnt_q + 1'b1;
                        // Only a length cut counts as overrun; a natural tlast on the
                        // last allowed beat does not.
                        overrun_q <= at_max & ~sel_last;
                    end
                    if (burst_end) begin
                        seq_q[last_q] <= seq_q[last_q] + 1'b1;
                        grant_q       <= '0;
                        state_q       <= StIdle;
                    end
                end

                default: begin
                    state_q <= StIdle;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tlast  = m_last_q;
    assign grant         = grant_q;
    assign overrun       = overrun_q;

endmodule
